// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that lets several requesters share one bank of JK flip-flops.
// One requester is granted per cycle and its {j,k} command is applied to the addressed bit.
module jk_bank_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 6,
    parameter int IW    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [2*NREQ-1:0]  cmd_i,
    input  logic [IW*NREQ-1:0] idx_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [WIDTH-1:0]   q_o,
    output logic [WIDTH-1:0]   qbar_o,
    output logic               upd_valid_o,
    output logic [2:0]         upd_src_o,
    output logic [IW-1:0]      upd_idx_o,
    output logic               err_o
);

    logic [2:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] bank_q, bank_d;
    logic             updValid_q, updValid_d;
    logic [2:0]       updSrc_q, updSrc_d;
    logic [IW-1:0]    updIdx_q, updIdx_d;
    logic             err_q, err_d;

    logic             found;
    logic [2:0]       winner;
    logic [1:0]       selCmd;
    logic [IW-1:0]    selIdx;
    logic             inRange;
    int               cand;

    // Search starts at the pointer and wraps; reset suppresses any grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        selCmd = '0;
        selIdx = '0;
        cand   = 0;
        for (int o = 0; o < NREQ; o++) begin
            cand = (int'(ptr_q) + o) % NREQ;
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = 3'(cand);
                selCmd = cmd_i[2*cand +: 2];
                selIdx = idx_i[IW*cand +: IW];
            end
        end
        if (!rst_i) begin
            found = 1'b0;
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = found && (winner == 3'(i));
        end
    end

    assign inRange = int'(selIdx) < WIDTH;

    // Out-of-range transfers still consume the grant but only raise err.
    always_comb begin
        bank_d     = bank_q;
        ptr_d      = ptr_q;
        updValid_d = 1'b0;
        updSrc_d   = updSrc_q;
        updIdx_d   = updIdx_q;
        err_d      = err_q;
        if (found) begin
            ptr_d      = (winner == 3'(NREQ-1)) ? 3'd0 : winner + 3'd1;
            updValid_d = 1'b1;
            updSrc_d   = winner;
            updIdx_d   = selIdx;
            if (!inRange) begin
                err_d = 1'b1;
            end
            for (int b = 0; b < WIDTH; b++) begin
                if (inRange && (selIdx == IW'(b))) begin
                    case (selCmd)
                        2'b01:   bank_d[b] = 1'b0;
                        2'b10:   bank_d[b] = 1'b1;
                        2'b11:   bank_d[b] = ~bank_q[b];
                        default: bank_d[b] = bank_q[b];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ptr_q      <= '0;
            bank_q     <= '0;
            updValid_q <= 1'b0;
            updSrc_q   <= '0;
            updIdx_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            bank_q     <= bank_d;
            updValid_q <= updValid_d;
            updSrc_q   <= updSrc_d;
            updIdx_q   <= updIdx_d;
            err_q      <= err_d;
        end
    end

    assign q_o         = bank_q;
    assign qbar_o      = ~bank_q;
    assign upd_valid_o = updValid_q;
    assign upd_src_o   = updSrc_q;
    assign upd_idx_o   = updIdx_q;
    assign err_o       = err_q;

endmodule

// File: doc/jk_bank_sched.md
# jk_bank_sched

Round-robin scheduler that shares a bank of JK flip-flops between several requesters. Each requester presents a JK command (hold/reset/set/toggle) and a target bit index. The block grants one requester per cycle and applies the winning command to the addressed bit of the bank. It sits between control agents and the JK state bank, and is the only writer of that bank.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 6: number of JK flip-flops in the bank.
- `IW`, default 3: index width per requester; indices >= `WIDTH` are out of range.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `req`  in  NREQ  request per requester; held until granted.
- `cmd`  in  2*NREQ  `{j,k}` per requester; requester r uses bits `[2r+1:2r]`.
- `idx`  in  IW*NREQ  target bit per requester; requester r uses bits `[IW*r+IW-1:IW*r]`.
- `gnt`  out  NREQ  one-hot grant, combinational, same cycle as `req`.
- `q`  out  WIDTH  bank state.
- `qbar`  out  WIDTH  always `~q`.
- `upd_valid`  out  1  registered pulse: a command was applied at the previous edge.
- `upd_src`  out  3  requester number of the last applied command.
- `upd_idx`  out  IW  index of the last applied command.
- `err`  out  1  sticky: an out-of-range index was granted.

## Operation
- **Command encoding** (`{j,k}`):
  - 00: hold.
  - 01: `q[idx]` <= 0.
  - 10: `q[idx]` <= 1.
  - 11: `q[idx]` <= `~q[idx]`.
- **Arbitration**: round-robin with a pointer `ptr` (0..NREQ-1).
  - Search starts at `ptr` and wraps modulo NREQ; the first asserted `req` wins.
  - `gnt` is one-hot for the winner and all-zero if no `req` is asserted.
- **Transfer**: a transfer completes at any edge where `req[r]` and `gnt[r]` are both high. At that edge:
  - The command is applied to the bank.
  - `ptr` <= (r+1) mod NREQ.
  - `upd_valid` <= 1, `upd_src` <= r, `upd_idx` <= `idx[r]`.
- **Idle cycle** (no `req`): `ptr` is unchanged, `upd_valid` <= 0, `upd_src`/`upd_idx` hold.
- **Hold command** (00): still a transfer. It consumes the grant, advances `ptr` and pulses `upd_valid`, but `q` is unchanged.
- **Out-of-range index** (`idx` >= WIDTH): still a transfer, but `q` is unchanged and `err` <= 1.
  - `err` stays set until reset.
- **Requester rules**: `cmd`/`idx` must be stable while `req` is high. A requester may keep `req` high after a grant to issue back-to-back commands, and is re-arbitrated every cycle.
- **Bank writes**: only one bit is written per cycle, so there are no write conflicts. Several requesters targeting the same bit are serialized in round-robin order.
- **Reset** (`rst`=0 at an edge), which overrides any transfer in that cycle:
  - `q` = 0, `qbar` = all ones.
  - `ptr` = 0.
  - `upd_valid` = 0, `upd_src` = 0, `upd_idx` = 0, `err` = 0.
  - `gnt` is forced to 0 while `rst`=0, so no transfer completes.

## Timing
- Grant latency: 0 cycles (combinational from `req` and `ptr`).
- Command-to-`q` latency: 1 edge; `q` reflects the command in the cycle after the grant.
- `upd_valid` is coincident with the updated `q`.
- Throughput: one command per cycle.
- Worst-case wait for a continuously asserted `req`: NREQ-1 grants.
- Reset deasserted at edge E: first possible transfer at edge E+1.
- Reset asserted in a cycle where `req` is high: no update; `q` reads 0 in the next cycle.

## Test plan
- **Reset**: hold `rst`=0 for 2 cycles with `req`=4'b1111 -> `gnt`=0, `q`=6'b000000, `qbar`=6'b111111, `err`=0, `upd_valid`=0.
- **Basic commands**: requester 0 issues `{j,k}`=10 at idx 2, then 11 at idx 2, then 01 at idx 5, then 11 at idx 2.
  - `q` after each command: 6'b000100, 6'b000000, 6'b000000, 6'b000100.
  - `upd_src`=0 each time.
- **Fairness**: `req`=4'b1111 held, all commands toggle at idx 0.
  - Grant order: 0,1,2,3,0,…
  - `q[0]` alternates 1,0,1,0.
  - Each requester gets exactly 2 grants in 8 cycles.
- **Pointer wrap**: grant requester 3 alone, then `req`=4'b0011 -> requester 0 granted first, then requester 1.
- **Out-of-range index**: requester 2 sends 10 at idx 7 -> `q` unchanged, `upd_valid`=1, `upd_idx`=7, `err`=1. `err` stays 1 until `rst`=0.
- **Mid-operation reset**: after `q`=6'b101010, with `req`=4'b0101, drive `rst`=0 for one cycle -> `q`=0 and `ptr`=0. Then requester 0 is granted first, not requester 2.
